d8_wb_regfile: RTL
==================

// Module: d8_wb_regfile
// PURPOSE
//  Write-back stage plus general register file of the dumb8 core. Sits directly downstream of
//  opcode decode/execute: it takes the decoded register-write enable, the destination index and
//  the ALU result, and holds them in one pipeline register. It commits them to the register file
//  one cycle later. Two combinational read ports serve operand fetch, with forwarding of the
//  pending write.
// PARAMETERS
//  WIDTH  8  data width of each register, in bits
//  NREGS  8  number of registers; AW = $clog2(NREGS) is a localparam, not a parameter
// PORTS
//  sys_clk      in   1      core clock; all state updates on its rising edge
//  sys_rst      in   1      synchronous reset, active-high
//  ex_valid     in   1      execute stage presents an instruction result
//  ex_ready     out  1      stage can accept; transfer happens when ex_valid & ex_ready
//  ex_we        in   1      decoded register-write enable for this opcode
//  ex_rd        in   AW     destination register index
//  ex_data      in   WIDTH  result to write
//  wb_hold      in   1      debug/stall: blocks commit of the pending entry
//  ra_addr      in   AW     read port A index
//  ra_data      out  WIDTH  read port A data (combinational)
//  rb_addr      in   AW     read port B index
//  rb_data      out  WIDTH  read port B data (combinational)
//  wb_retired   out  16     count of committed entries (write or not)
// BEHAVIOUR
//  - Reset values:
//    - all registers = 0; wb_valid_q = 0; wb_retired = 0; ex_ready = 1 after reset.
//    - ra_data/rb_data then read 0.
//  - Pipeline register {wb_valid_q, wb_we_q, wb_rd_q, wb_data_q}:
//    - loaded on ex_valid & ex_ready.
//    - if nothing is accepted and the entry commits, wb_valid_q <= 0.
//  - Commit condition: wb_valid_q & !wb_hold.
//    - If wb_we_q, regs[wb_rd_q] <= wb_data_q.
//    - wb_retired increments by 1 and wraps 0xFFFF -> 0x0000.
//    - Commit is 1 cycle after acceptance when wb_hold is low.
//  - ex_ready = !(wb_valid_q & wb_hold).
//    - Combinational from state and wb_hold only; never from ex_valid.
//  - Simultaneous commit and accept: both happen in the same cycle.
//    - The new entry replaces the committed one and wb_valid_q stays 1.
//    - Full throughput is 1 instruction per cycle.
//  - Held entry: while wb_hold is high, the stage contents are stable and ex_ready = 0.
//  - Reads, per port independently:
//    - if wb_valid_q & wb_we_q & (addr == wb_rd_q), return wb_data_q (forward);
//    - otherwise return regs[addr].
//    - Forwarding applies even while wb_hold is high.
//  - A read of the register being committed this cycle returns the new value, via forwarding.
//  - ex_we = 0 entries flow through and count as retired but modify no register.
//  - Reset mid-operation: the pending entry is discarded, not committed, and the counter clears.
//  - Out-of-range index (NREGS not a power of 2): reads return 0 and writes are dropped.
// CONFIGURATION
//  D8_R0_ZERO_EN defined:
//    - register 0 is hardwired to 0; writes to index 0 are dropped, but the entry still retires;
//    - reads of index 0 return 0 and are never forwarded.
//  D8_R0_ZERO_EN undefined: register 0 is an ordinary register.
// STRUCTURE
//  - Shared include d8_defs.vh: WIDTH/NREGS defaults, register index constants, opcode constants.
//  - Sub-module d8_regfile_mem: the storage array with two async read ports and one sync write
//    port, with reset clear. It holds the D8_R0_ZERO_EN handling.
//  - The stage register, handshake, forwarding muxes and counter stay in d8_wb_regfile.
// TESTING
//  - Reset: hold sys_rst 2 cycles, then read all 8 indices.
//    -> every read 0x00, wb_retired = 0, ex_ready = 1.
//  - Basic write: accept {we=1, rd=3, data=0xA5}; same cycle+1 ra_addr=3 -> 0xA5 (forward).
//    -> cycle+2 still 0xA5 from the array; wb_retired = 1.
//  - Back-to-back: 4 consecutive accepts r1=0x11, r2=0x22, r1=0x33, r4=0x44.
//    -> ex_ready stays 1, final r1=0x33, r2=0x22, r4=0x44, wb_retired = 4.
//  - Hold: pending {rd=5, 0x5A} with wb_hold=1 for 3 cycles and ex_valid=1.
//    -> ex_ready=0 and r5 array unchanged while held; rb_addr=5 reads 0x5A (forward).
//    -> on release, commit plus accept happen in the same cycle.
//  - No-write op and wrap: accept {we=0, rd=2, 0xFF}, so r2 is unchanged.
//    -> preload the counter to 0xFFFF via 65535 retires, then one more retire -> 0x0000.
//  - Reset mid-op, then D8_R0_ZERO_EN:
//    - assert sys_rst while {rd=6, 0x66} is pending -> r6 = 0.
//    - with the macro, write {rd=0, 0x77} -> r0 reads 0 and wb_retired increments.

Source files
------------

// File: rtl/d8_wb_regfile_pkg.sv
// d8_wb_regfile_pkg: shared dumb8 defaults, register index and opcode constants
package d8_wb_regfile_pkg;
    localparam int D8_WIDTH = 8;
    localparam int D8_NREGS = 8;
    localparam logic [2:0] D8_R0 = 3'd0;
    localparam logic [2:0] D8_R1 = 3'd1;
    localparam logic [2:0] D8_R2 = 3'd2;
    localparam logic [2:0] D8_R3 = 3'd3;
    localparam logic [2:0] D8_R4 = 3'd4;
    localparam logic [2:0] D8_R5 = 3'd5;
    localparam logic [2:0] D8_R6 = 3'd6;
    localparam logic [2:0] D8_R7 = 3'd7;
    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_AND = 4'h3,
        OP_OR  = 4'h4,
        OP_XOR = 4'h5,
        OP_LDI = 4'h6,
        OP_MOV = 4'h7,
        OP_CMP = 4'h8,
        OP_JMP = 4'h9
    } d8_op_e;
endpackage

// File: rtl/d8_wb_regfile_if.sv
// d8_wb_regfile_if: execute-to-writeback result handshake (valid/ready plus decoded write)
interface d8_wb_regfile_if
    import d8_wb_regfile_pkg::*;
#(
    parameter int WIDTH = D8_WIDTH,
    parameter int NREGS = D8_NREGS
);
    localparam int AW = $clog2(NREGS);
    logic             valid;
    logic             ready;
    logic             we;
    logic [AW-1:0]    rd;
    logic [WIDTH-1:0] data;
    modport master (output valid, we, rd, data, input ready);
    modport slave (input valid, we, rd, data, output ready);
endinterface

// File: rtl/d8_regfile_mem.sv
// d8_regfile_mem: register storage, two async reads, one sync write; D8_R0_ZERO_EN hardwires r0 to 0
module d8_regfile_mem #(
    parameter int WIDTH = 8,
    parameter int NREGS = 8,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic [AW-1:0]    ra_addr,
    output logic [WIDTH-1:0] ra_data,
    input  logic [AW-1:0]    rb_addr,
    output logic [WIDTH-1:0] rb_data
);
`ifdef D8_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif
    localparam logic [AW:0] NR = (AW+1)'(NREGS);
    logic [WIDTH-1:0] regs [NREGS];
    function automatic logic usable(input logic [AW-1:0] a);
        return ({1'b0, a} < NR) && !(R0Z && a == '0);
    endfunction
    // clear on reset, otherwise write only legal indices
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we && usable(wa)) begin
            regs[wa] <= wd;
        end
    end
    // illegal or hardwired indices read as zero
    always_comb begin
        ra_data = usable(ra_addr) ? regs[ra_addr] : '0;
        rb_data = usable(rb_addr) ? regs[rb_addr] : '0;
    end
endmodule

// File: rtl/d8_wb_regfile.sv
// d8_wb_regfile: write-back stage register, commit handshake, read forwarding, retire counter (D8_R0_ZERO_EN optional)
module d8_wb_regfile
    import d8_wb_regfile_pkg::*;
#(
    parameter int WIDTH = D8_WIDTH,
    parameter int NREGS = D8_NREGS,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    d8_wb_regfile_if.slave   ex,
    input  logic             wb_hold,
    input  logic [AW-1:0]    ra_addr,
    output logic [WIDTH-1:0] ra_data,
    input  logic [AW-1:0]    rb_addr,
    output logic [WIDTH-1:0] rb_data,
    output logic [15:0]      wb_retired
);
`ifdef D8_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif
    localparam logic [AW:0] NR = (AW+1)'(NREGS);
    logic             wb_valid_q;
    logic             wb_we_q;
    logic [AW-1:0]    wb_rd_q;
    logic [WIDTH-1:0] wb_data_q;
    logic [WIDTH-1:0] mem_a;
    logic [WIDTH-1:0] mem_b;
    logic             commit;
    logic             accept;
    assign ex.ready = !(wb_valid_q && wb_hold);
    assign commit   = wb_valid_q && !wb_hold;
    assign accept   = ex.valid && ex.ready;
    function automatic logic fwd(input logic [AW-1:0] a);
        return wb_valid_q && wb_we_q && a == wb_rd_q && {1'b0, a} < NR && !(R0Z && a == '0);
    endfunction
    d8_regfile_mem #(.WIDTH(WIDTH), .NREGS(NREGS)) u_mem (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .we      (commit && wb_we_q),
        .wa      (wb_rd_q),
        .wd      (wb_data_q),
        .ra_addr (ra_addr),
        .ra_data (mem_a),
        .rb_addr (rb_addr),
        .rb_data (mem_b)
    );
    // stage register: a new entry replaces a committing one; a lone commit empties the stage
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            wb_retired <= '0;
        end else begin
            if (accept) begin
                wb_valid_q <= 1'b1;
                wb_we_q    <= ex.we;
                wb_rd_q    <= ex.rd;
                wb_data_q  <= ex.data;
            end else if (commit) begin
                wb_valid_q <= 1'b0;
            end
            if (commit) wb_retired <= wb_retired + 16'd1;
        end
    end
    // pending write wins over the array, even while held
    always_comb begin
        ra_data = fwd(ra_addr) ? wb_data_q : mem_a;
        rb_data = fwd(rb_addr) ? wb_data_q : mem_b;
    end
endmodule
